exibe_sequencia: RTL and testbench

//  Presents the stored game sequence to the player: reads sync_rom_16x4 entries 0..limite in order and shows each on leds[3:0] for T_ON cycles, then dark for T_OFF cycles.
//  It is the output-side counterpart of the jogada input path. The control unit pulses iniciar, waits for pronto, then enables player input.

---
 rtl/exibe_sequencia_pkg.sv | 29 ++
 rtl/exibe_sequencia_if.sv | 29 ++
 rtl/exibe_sequencia_temporizador.sv | 37 +++
 rtl/exibe_sequencia.sv | 124 ++++++++++++
 tb/tb_exibe_sequencia.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/exibe_sequencia_pkg.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_pkg
// Shared definitions for the sequence-display block and the control unit that
// decodes its db_estado output: state codes, address/data widths and a helper
// that widens a state into the 4-bit debug code.
// -----------------------------------------------------------------------------
package exibe_sequencia_pkg;

  localparam int ADDR_W = 4;  // ROM address width (16 entries)
  localparam int DATA_W = 4;  // ROM data / leds width
  localparam int DBG_W  = 4;  // width of the db_estado debug code

  // State codes are visible outside the block through db_estado, so the
  // encoding is fixed rather than left to the synthesis tool.
  typedef enum logic [2:0] {
    ST_INICIAL = 3'd0,
    ST_BUSCA   = 3'd1,
    ST_CARREGA = 3'd2,
    ST_ACENDE  = 3'd3,
    ST_APAGA   = 3'd4,
    ST_PROXIMO = 3'd5,
    ST_FIM     = 3'd6
  } estado_e;

  function automatic logic [DBG_W-1:0] estado_code(input estado_e st);
    return {1'b0, st};
  endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_if
// Groups the control handshake (iniciar/limite/ocupado/pronto), the ROM port
// (rom_endereco/rom_dado), the leds and the debug state code.
//   slave  : the display block (drives ROM address, leds, status)
//   master : control unit plus ROM (drives iniciar, limite, rom_dado)
// -----------------------------------------------------------------------------
interface exibe_sequencia_if;
  import exibe_sequencia_pkg::*;

  logic                iniciar;
  logic [ADDR_W-1:0]   limite;
  logic [DATA_W-1:0]   rom_dado;
  logic [ADDR_W-1:0]   rom_endereco;
  logic [DATA_W-1:0]   leds;
  logic                ocupado;
  logic                pronto;
  logic [DBG_W-1:0]    db_estado;

  modport slave (
    input  iniciar, limite, rom_dado,
    output rom_endereco, leds, ocupado, pronto, db_estado
  );

  modport master (
    output iniciar, limite, rom_dado,
    input  rom_endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia_temporizador.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_temporizador
// Down-counter used to time the lit and dark phases of each entry.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value to load (phase length minus one)
//   zero_o       : count is zero; the counter holds at zero until reloaded
// -----------------------------------------------------------------------------
module exibe_sequencia_temporizador #(
  parameter int TW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)       cnt_d = load_val_i;
    else if (!zero_o) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
// Plays the stored game sequence: reads ROM entries 0..limite in order and
// shows each one on leds for T_ON cycles, followed by T_OFF dark cycles.
// Each entry costs 3 + T_ON + T_OFF cycles (BUSCA, CARREGA, lit, dark,
// PROXIMO); a final FIM cycle pulses pronto.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   bus.iniciar         : start request, only honoured when idle (or in FIM)
//   bus.limite          : last address to show, captured at start
//   bus.rom_dado        : ROM data, valid one cycle after rom_endereco
//   bus.rom_endereco    : registered ROM address
//   bus.leds            : registered display value
//   bus.ocupado         : high in every state except INICIAL
//   bus.pronto          : one-cycle pulse in FIM
//   bus.db_estado       : current state code
// -----------------------------------------------------------------------------
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500,
  parameter int TW    = 16
) (
  input  logic              clock,
  input  logic              reset,
  exibe_sequencia_if.slave  bus
);

  estado_e             state_q, state_d;
  logic [ADDR_W-1:0]   end_q;    // ROM address register
  logic [ADDR_W-1:0]   lim_q;    // limite captured at start
  logic [DATA_W-1:0]   dado_q;   // entry currently displayed
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic                pronto_q;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_zero;
  logic                start;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INICIAL: if (bus.iniciar) state_d = ST_BUSCA;
      ST_BUSCA:   state_d = ST_CARREGA;
      ST_CARREGA: state_d = ST_ACENDE;
      ST_ACENDE:  if (tmr_zero) state_d = ST_APAGA;
      ST_APAGA:   if (tmr_zero) state_d = ST_PROXIMO;
      ST_PROXIMO: state_d = (end_q == lim_q) ? ST_FIM : ST_BUSCA;
      // A start request held through FIM restarts on the very next cycle,
      // exactly as if INICIAL had been passed through with iniciar high.
      ST_FIM:     state_d = bus.iniciar ? ST_BUSCA : ST_INICIAL;
      default:    state_d = ST_INICIAL;
    endcase
  end

  // A new sequence begins whenever BUSCA is entered from idle or from FIM;
  // only then are the address cleared and limite sampled.
  assign start = (state_d == ST_BUSCA) &&
                 ((state_q == ST_INICIAL) || (state_q == ST_FIM));

  // ---------------------------------------------------------------------------
  // Phase timer: loaded with T_ON-1 entering ACENDE, T_OFF-1 entering APAGA,
  // so each phase lasts exactly its programmed number of cycles.
  // ---------------------------------------------------------------------------
  assign tmr_load = (state_q == ST_CARREGA) ||
                    ((state_q == ST_ACENDE) && tmr_zero);
  assign tmr_val  = (state_q == ST_CARREGA) ? TW'(T_ON - 1) : TW'(T_OFF - 1);

  exibe_sequencia_temporizador #(.TW(TW)) u_temporizador (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // leds are lit only while in ACENDE. On the CARREGA->ACENDE edge the ROM
  // word is registered straight into leds (and dado_q) so the first lit cycle
  // already shows it; there is never a combinational path to the output.
  always_comb begin
    leds_d = '0;
    if (state_d == ST_ACENDE)
      leds_d = (state_q == ST_CARREGA) ? bus.rom_dado : dado_q;
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INICIAL;
      end_q    <= '0;
      lim_q    <= '0;
      dado_q   <= '0;
      leds_q   <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      leds_q   <= leds_d;
      pronto_q <= (state_d == ST_FIM);
      if (start) begin
        end_q <= '0;
        lim_q <= bus.limite;
      end else if ((state_q == ST_PROXIMO) && (state_d == ST_BUSCA)) begin
        // Only reached when end_q != lim_q, so the address never wraps.
        end_q <= end_q + 1'b1;
      end
      if (state_q == ST_CARREGA) dado_q <= bus.rom_dado;
    end
  end

  assign bus.rom_endereco = end_q;
  assign bus.leds         = leds_q;
  assign bus.pronto       = pronto_q;
  assign bus.ocupado      = (state_q != ST_INICIAL);
  assign bus.db_estado    = estado_code(state_q);

endmodule

// File: tb/tb_exibe_sequencia.sv
// -----------------------------------------------------------------------------
// tb_exibe_sequencia
// Directed bench for exibe_sequencia with T_ON=4, T_OFF=2 (9 cycles/entry).
// A 16x4 synchronous ROM model with one cycle of latency feeds the DUT.
// Cycle c is the clock period that follows rising edge c-1, where edge 0 is
// the edge that samples the start request.
// -----------------------------------------------------------------------------
module tb_exibe_sequencia;
  import exibe_sequencia_pkg::*;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int PER   = 3 + T_ON + T_OFF;

  logic clock = 1'b0;
  logic reset = 1'b1;

  exibe_sequencia_if bus ();

  exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Synchronous ROM model, one cycle of read latency.
  logic [3:0] rom [16];
  int         max_addr;

  always @(posedge clock) begin
    bus.rom_dado <= rom[bus.rom_endereco];
    if (int'(bus.rom_endereco) > max_addr) max_addr = int'(bus.rom_endereco);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a sequence at edge 0 and checks every output each cycle against a
  // model of the expected waveform. hold: iniciar stays high while c < hold.
  // noise: spurious iniciar pulses in lit/dark phases, limite moved to 5.
  // n_runs: number of back-to-back runs expected (for a held start request).
  task automatic run_seq(input int lim, input int hold, input bit noise,
                         input int n_runs, input string name);
    int len, total, r, cc, k, p;
    logic [3:0] e_leds, e_addr, e_db;
    logic       e_ocu, e_pr;
    len   = PER * (lim + 1) + 1;
    total = n_runs * len + 2;
    @(negedge clock);
    bus.limite  = 4'(lim);
    bus.iniciar = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= total; c++) begin
      if (c > 1) @(posedge clock);
      #1;
      r = (c - 1) / len;
      if (r > n_runs - 1) r = n_runs - 1;
      cc = c - r * len;
      p  = -1;
      e_leds = 4'd0;
      e_addr = 4'(lim);
      e_pr   = 1'b0;
      if (cc > len) begin
        e_db = 4'd0; e_ocu = 1'b0;
      end else if (cc == len) begin
        e_db = 4'd6; e_ocu = 1'b1; e_pr = 1'b1;
      end else begin
        k = (cc - 1) / PER;
        p = (cc - 1) % PER;
        e_ocu  = 1'b1;
        e_addr = 4'(k);
        if (p == 0)                 e_db = 4'd1;
        else if (p == 1)            e_db = 4'd2;
        else if (p < 2 + T_ON)      begin e_db = 4'd3; e_leds = rom[k]; end
        else if (p < 2 + T_ON + T_OFF) e_db = 4'd4;
        else                        e_db = 4'd5;
      end
      check($sformatf("%s c%0d leds", name, c), 32'(bus.leds), 32'(e_leds));
      check($sformatf("%s c%0d addr", name, c), 32'(bus.rom_endereco), 32'(e_addr));
      check($sformatf("%s c%0d estado", name, c), 32'(bus.db_estado), 32'(e_db));
      check($sformatf("%s c%0d ocupado", name, c), 32'(bus.ocupado), 32'(e_ocu));
      check($sformatf("%s c%0d pronto", name, c), 32'(bus.pronto), 32'(e_pr));
      bus.iniciar = (c < hold) ||
                    (noise && p >= 2 && p <= 7 && (c % 2 == 1));
      if (noise && c >= 3) bus.limite = 4'd5;
    end
    bus.iniciar = 1'b0;
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
    max_addr    = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'd0;

    // Reset state
    #1;
    check("rst leds",    32'(bus.leds),         32'd0);
    check("rst addr",    32'(bus.rom_endereco), 32'd0);
    check("rst estado",  32'(bus.db_estado),    32'd0);
    check("rst ocupado", 32'(bus.ocupado),      32'd0);
    check("rst pronto",  32'(bus.pronto),       32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // T1: reset asserted in the middle of ACENDE aborts immediately
    rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4;
    @(negedge clock);
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    @(posedge clock);
    #1 bus.iniciar = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("T1 pre leds",   32'(bus.leds),      32'd1);
    check("T1 pre estado", 32'(bus.db_estado), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("T1 rst leds",    32'(bus.leds),         32'd0);
    check("T1 rst ocupado", 32'(bus.ocupado),      32'd0);
    check("T1 rst estado",  32'(bus.db_estado),    32'd0);
    check("T1 rst addr",    32'(bus.rom_endereco), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("T1 idle%0d estado", i), 32'(bus.db_estado), 32'd0);
      check($sformatf("T1 idle%0d pronto", i), 32'(bus.pronto),    32'd0);
      check($sformatf("T1 idle%0d leds", i),   32'(bus.leds),      32'd0);
    end

    // T2: three entries 1,2,4; pronto in cycle 28
    run_seq(2, 0, 1'b0, 1, "T2");

    // T3: single entry
    rom[0] = 4'd8;
    run_seq(0, 0, 1'b0, 1, "T3");

    // T4: all 16 entries in order; ROM[0]=0 also covers a dark entry
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    max_addr = 0;
    run_seq(15, 0, 1'b0, 1, "T4");
    check("T4 max addr", 32'(max_addr), 32'd15);

    // T5: stray starts and limite change while busy are ignored
    rom[0] = 4'hA; rom[1] = 4'h5;
    run_seq(1, 0, 1'b1, 1, "T5");

    // T6: iniciar held for 40 cycles -> back-to-back runs starting at 1, 20, 39
    rom[0] = 4'h3; rom[1] = 4'hC;
    run_seq(1, 40, 1'b0, 3, "T6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
